// File: rtl/ascon_permutation_engine_pkg.sv
// Shared Ascon types, FSM encoding, round-count constants and small helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ascon_pack;

  // x0 is element 0 and occupies the most significant 64 bits of the packed vector
  typedef logic [0:4][63:0] type_state;

  typedef enum logic [1:0] {IDLE, RUN, DONE} type_fsm;

  localparam int ROUNDS_A  = 12;
  localparam int ROUNDS_B6 = 6;
  localparam int ROUNDS_B8 = 8;

  // Round constant for round index i, XORed into x2[7:0]
  function automatic logic [7:0] round_const(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

  // 64-bit rotate right by a constant amount
  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // First round index for the selected round count (index runs up to 11)
  function automatic logic [3:0] start_index(input logic [1:0] sel);
    case (sel)
      2'b01:   return 4'(ROUNDS_A - ROUNDS_B8);
      2'b10:   return 4'(ROUNDS_A - ROUNDS_B6);
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One Ascon round: constant addition, bit-sliced 5-bit S-box, linear diffusion.
// Latency: purely combinational.
// Backpressure: none; the caller sequences rounds.
module ascon_round
  import ascon_pack::*;
(
  input  type_state   state_in,
  input  logic [3:0]  idx,
  output type_state   state_out
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  // Constant add, then the S-box as the reference bit-sliced instruction sequence, then diffusion
  always_comb begin
    x0 = state_in[0];
    x1 = state_in[1];
    x2 = state_in[2] ^ {56'd0, round_const(idx)};
    x3 = state_in[3];
    x4 = state_in[4];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    state_out[0] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    state_out[1] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    state_out[2] = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    state_out[3] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    state_out[4] = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
  end

endmodule

// File: rtl/ascon_permutation_engine.sv
// Self-sequenced Ascon p12/p8/p6 with optional data pre-XOR and key post-XOR.
// Latency: N/UNROLL cycles from the accept edge to valid_o.
// Backpressure: result held in DONE until ready_i; a new state may be accepted on the same edge.
module ascon_permutation_engine
  import ascon_pack::*;
#(
  parameter int UNROLL = 1
) (
  input  logic          clock_i,
  input  logic          resetb_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  type_state     state_i,
  input  logic [1:0]    rounds_sel_i,
  input  logic          en_xor_data_i,
  input  logic [63:0]   data_i,
  input  logic          en_xor_key_i,
  input  logic [127:0]  key_i,
  output logic          valid_o,
  input  logic          ready_i,
  output type_state     state_o,
  output logic [3:0]    round_o,
  output logic          busy_o
);

  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("ascon_permutation_engine: UNROLL must be 1 or 2");
  end

  type_fsm        fsm;
  type_state      st_q;
  logic [3:0]     rnd_q;
  logic           key_en_q;
  logic [127:0]   key_q;
  logic           valid_q;
  logic           busy_q;

  type_state      chain [0:UNROLL];
  type_state      round_out;
  type_state      load_state;
  logic           last_step;
  logic           accept;

  assign chain[0] = st_q;

  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    ascon_round u_round (
      .state_in  (chain[k]),
      .idx       (rnd_q + 4'(k)),
      .state_out (chain[k+1])
    );
  end

  // This step finishes round 11 when the counter sits UNROLL short of 12
  assign last_step = (rnd_q == 4'(ROUNDS_A - UNROLL));

  // Ready depends only on FSM state and ready_i, never on valid_i
  assign ready_o = (fsm == IDLE) | ((fsm == DONE) & ready_i);
  assign accept  = valid_i & ready_o;

  // Round chain output, with the latched key folded into x3/x4 on the final step
  always_comb begin
    round_out = chain[UNROLL];
    if (last_step && key_en_q) begin
      round_out[3] = chain[UNROLL][3] ^ key_q[127:64];
      round_out[4] = chain[UNROLL][4] ^ key_q[63:0];
    end
  end

  // Incoming state with the optional data word folded into x0
  always_comb begin
    load_state = state_i;
    if (en_xor_data_i) begin
      load_state[0] = state_i[0] ^ data_i;
    end
  end

  // FSM, round counter, latched configuration and state register
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm      <= IDLE;
      st_q     <= '0;
      rnd_q    <= '0;
      key_en_q <= 1'b0;
      key_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else if (accept) begin
      fsm      <= RUN;
      st_q     <= load_state;
      rnd_q    <= start_index(rounds_sel_i);
      key_en_q <= en_xor_key_i;
      key_q    <= key_i;
      valid_q  <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      case (fsm)
        RUN: begin
          st_q  <= round_out;
          rnd_q <= rnd_q + 4'(UNROLL);
          if (last_step) begin
            fsm     <= DONE;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          if (ready_i) begin
            fsm     <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_o = st_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign round_o = rnd_q;

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Directed bench for ascon_permutation_engine with a table-driven S-box reference model.
// Latency: checks N/UNROLL accept-to-valid and the per-cycle round index.
// Backpressure: holds ready_i low in DONE and exercises back-to-back accepts.
module tb_ascon_permutation_engine;
  import ascon_pack::*;

  localparam int U = 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  type_state     state_i = '0;
  logic [1:0]    rounds_sel_i = 2'b00;
  logic          en_xor_data_i = 1'b0;
  logic [63:0]   data_i = '0;
  logic          en_xor_key_i = 1'b0;
  logic [127:0]  key_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  type_state     state_o;
  logic [3:0]    round_o;
  logic          busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ascon_permutation_engine #(.UNROLL(U)) dut (
    .clock_i       (clk),
    .resetb_i      (rstn),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .state_i       (state_i),
    .rounds_sel_i  (rounds_sel_i),
    .en_xor_data_i (en_xor_data_i),
    .data_i        (data_i),
    .en_xor_key_i  (en_xor_key_i),
    .key_i         (key_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .state_o       (state_o),
    .round_o       (round_o),
    .busy_o        (busy_o)
  );

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Ascon S-box as the published lookup table, x0 is the MSB of the column
  function automatic logic [4:0] sbox(input logic [4:0] v);
    case (v)
      5'd0:  return 5'h04;  5'd1:  return 5'h0b;  5'd2:  return 5'h1f;  5'd3:  return 5'h14;
      5'd4:  return 5'h1a;  5'd5:  return 5'h15;  5'd6:  return 5'h09;  5'd7:  return 5'h02;
      5'd8:  return 5'h1b;  5'd9:  return 5'h05;  5'd10: return 5'h08;  5'd11: return 5'h12;
      5'd12: return 5'h1d;  5'd13: return 5'h03;  5'd14: return 5'h06;  5'd15: return 5'h1c;
      5'd16: return 5'h1e;  5'd17: return 5'h13;  5'd18: return 5'h07;  5'd19: return 5'h0e;
      5'd20: return 5'h00;  5'd21: return 5'h0d;  5'd22: return 5'h11;  5'd23: return 5'h18;
      5'd24: return 5'h10;  5'd25: return 5'h0c;  5'd26: return 5'h01;  5'd27: return 5'h19;
      5'd28: return 5'h16;  5'd29: return 5'h0a;  5'd30: return 5'h0f;  default: return 5'h17;
    endcase
  endfunction

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x};
    return d[n +: 64];
  endfunction

  function automatic type_state m_round(input type_state s, input int r);
    type_state o;
    logic [4:0] res;
    s[2][7:0] = s[2][7:0] ^ 8'(((15 - r) << 4) | r);
    for (int b = 0; b < 64; b++) begin
      res = sbox({s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]});
      o[0][b] = res[4]; o[1][b] = res[3]; o[2][b] = res[2]; o[3][b] = res[1]; o[4][b] = res[0];
    end
    s = o;
    o[0] = s[0] ^ rr(s[0], 19) ^ rr(s[0], 28);
    o[1] = s[1] ^ rr(s[1], 61) ^ rr(s[1], 39);
    o[2] = s[2] ^ rr(s[2], 1)  ^ rr(s[2], 6);
    o[3] = s[3] ^ rr(s[3], 10) ^ rr(s[3], 17);
    o[4] = s[4] ^ rr(s[4], 7)  ^ rr(s[4], 41);
    return o;
  endfunction

  function automatic type_state m_perm(input type_state s, input logic [63:0] d, input logic xd,
                                       input int start, input logic xk, input logic [127:0] k);
    if (xd) s[0] = s[0] ^ d;
    for (int r = start; r < 12; r++) s = m_round(s, r);
    if (xk) begin
      s[3] = s[3] ^ k[127:64];
      s[4] = s[4] ^ k[63:0];
    end
    return s;
  endfunction

  // Called at negedge: present a state with ready_i=1, then follow it through RUN to DONE
  task automatic run_perm(input string tag, input type_state s, input logic [1:0] sel,
                          input logic xd, input logic [63:0] d, input logic xk,
                          input logic [127:0] k, input int exp_start, input int n_rounds,
                          input bit noise);
    type_state exp;
    int cyc;
    exp = m_perm(s, d, xd, exp_start, xk, k);
    state_i = s; rounds_sel_i = sel; en_xor_data_i = xd; data_i = d;
    en_xor_key_i = xk; key_i = k; valid_i = 1'b1; ready_i = 1'b1;
    #1 chk({tag, ":ready_accept"}, ready_o, 1'b1);
    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b0;
    #1;
    chk({tag, ":busy"}, busy_o, 1'b1);
    chk({tag, ":ready_run"}, ready_o, 1'b0);
    chk({tag, ":valid_run"}, valid_o, 1'b0);
    cyc = 0;
    while (!valid_o && cyc < 40) begin
      chk({tag, ":round"}, round_o, exp_start + cyc * U);
      if (noise) begin
        state_i = {$urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom, $urandom};
        rounds_sel_i = 2'($urandom);
        key_i = {$urandom, $urandom, $urandom, $urandom};
        data_i = {$urandom, $urandom};
        en_xor_key_i = ~en_xor_key_i;
        en_xor_data_i = ~en_xor_data_i;
        valid_i = 1'($urandom);
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    valid_i = 1'b0;
    chk({tag, ":latency"}, cyc, n_rounds / U);
    chk({tag, ":state"}, state_o, exp);
    chk({tag, ":busy_done"}, busy_o, 1'b0);
  endtask

  task automatic consume(input string tag);
    ready_i = 1'b1;
    @(negedge clk);
    #1;
    chk({tag, ":valid_after_take"}, valid_o, 1'b0);
    chk({tag, ":ready_idle"}, ready_o, 1'b1);
    ready_i = 1'b0;
  endtask

  type_state s_iv;
  type_state hold_exp;
  type_state zero_st;
  type_state r0_exp;
  logic [127:0] k0;
  int guard;

  initial begin
    s_iv = {64'h80400C0600000000, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
            64'h0011223344556677, 64'h8899AABBCCDDEEFF};
    k0 = 128'h000102030405060708090A0B0C0D0E0F;
    zero_st = '0;
    // One round on the zero state at index 0, worked out by hand
    r0_exp = {64'h001E0F00000000F0, 64'h00000001E0000770, 64'h3FFFFFFFFFFFFF74,
              64'h3C780000000000F0, 64'h0000000000000000};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", state_o, zero_st);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_round", round_o, 4'd0);
    rstn = 1'b1;
    #1 chk("rst_ready", ready_o, 1'b1);
    @(negedge clk);

    chk("model_round0", m_round(zero_st, 0), r0_exp);

    run_perm("p12_key", s_iv, 2'b00, 1'b0, 64'd0, 1'b1, k0, 0, 12, 1'b0);
    consume("p12_key");
    @(negedge clk);

    run_perm("p6_data", s_iv, 2'b10, 1'b1, 64'h8000000000000000, 1'b0, k0, 6, 6, 1'b0);
    consume("p6_data");
    @(negedge clk);

    run_perm("p8", s_iv, 2'b01, 1'b0, 64'd0, 1'b0, '0, 4, 8, 1'b0);
    hold_exp = m_perm(s_iv, 64'd0, 1'b0, 4, 1'b0, '0);
    // Backpressure with a pending valid that must not be taken
    valid_i = 1'b1;
    state_i = ~s_iv;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", valid_o, 1'b1);
      chk("hold_state", state_o, hold_exp);
      chk("hold_ready", ready_o, 1'b0);
    end
    valid_i = 1'b0;

    run_perm("sel11_b2b", s_iv, 2'b11, 1'b1, 64'h0123456789ABCDEF, 1'b1, k0, 0, 12, 1'b0);
    run_perm("noise_b2b", s_iv, 2'b00, 1'b0, 64'd0, 1'b1, ~k0, 0, 12, 1'b1);
    consume("noise_b2b");
    @(negedge clk);

    // Abort mid-RUN
    state_i = s_iv; rounds_sel_i = 2'b00; en_xor_key_i = 1'b1; key_i = k0;
    en_xor_data_i = 1'b0; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    guard = 0;
    while (round_o < 4'd5 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_reached_round5", guard < 20, 1'b1);
    #1 rstn = 1'b0;
    #1;
    chk("abort_state", state_o, zero_st);
    chk("abort_valid", valid_o, 1'b0);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_round", round_o, 4'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    chk("post_abort_ready", ready_o, 1'b1);
    chk("post_abort_valid", valid_o, 1'b0);
    run_perm("post_abort", s_iv, 2'b00, 1'b0, 64'd0, 1'b1, k0, 0, 12, 1'b0);
    consume("post_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
